// File: rtl/alu64_if.sv
// Operand/result bundle for the registered 64-bit ALU.
// The master issues operands and an opcode; the slave returns the registered result and flags.
interface alu64_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       sel;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             z_f;
    logic             o_f;

    modport master (
        output in_valid, a, b, sel,
        input  out_valid, result, z_f, o_f
    );

    modport slave (
        input  in_valid, a, b, sel,
        output out_valid, result, z_f, o_f
    );
endinterface

// File: rtl/alu64.sv
// Registered signed ALU (add/sub/mul/div/and/or) with zero and overflow flags.
// The operation is computed combinationally and captured one clock after in_valid.
module alu64 #(
    parameter int WIDTH = 64
) (
    input  logic   clk,
    input  logic   rst_n,
    alu64_if.slave bus
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0]        sum;
    logic [WIDTH-1:0]        diff;
    logic [2*WIDTH-1:0]      prod;
    logic                    div_by_zero;
    logic                    div_ovf;
    logic signed [WIDTH-1:0] div_b;
    logic signed [WIDTH-1:0] quot;
    logic [WIDTH-1:0]        op_res;
    logic                    op_ovf;

    logic             out_valid_d, out_valid_q;
    logic [WIDTH-1:0] result_d, result_q;
    logic             z_f_d, z_f_q;
    logic             o_f_d, o_f_q;

    // Sign-extending both operands to 2*WIDTH makes the unsigned product equal the signed one.
    always_comb begin
        sum         = bus.a + bus.b;
        diff        = bus.a - bus.b;
        prod        = {{WIDTH{bus.a[WIDTH-1]}}, bus.a} * {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
        div_by_zero = (bus.b == '0);
        div_ovf     = (bus.a == MOST_NEG) && (bus.b == '1);
        // Substitute a harmless divisor for the two special cases so the divider never sees them.
        if (div_by_zero || div_ovf) begin
            div_b = {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            div_b = $signed(bus.b);
        end
        quot = $signed(bus.a) / div_b;

        op_res = '0;
        op_ovf = 1'b0;
        case (bus.sel)
            OP_ADD: begin
                op_res = sum;
                op_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                op_res = diff;
                op_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_MUL: begin
                op_res = prod[WIDTH-1:0];
                op_ovf = (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
            end
            OP_DIV: begin
                if (div_by_zero) begin
                    op_res = '1;
                    op_ovf = 1'b1;
                end else if (div_ovf) begin
                    op_res = MOST_NEG;
                    op_ovf = 1'b1;
                end else begin
                    op_res = quot;
                end
            end
            OP_AND:  op_res = bus.a & bus.b;
            OP_OR:   op_res = bus.a | bus.b;
            default: op_res = '0;
        endcase
    end

    always_comb begin
        out_valid_d = bus.in_valid;
        result_d    = result_q;
        z_f_d       = z_f_q;
        o_f_d       = o_f_q;
        if (bus.in_valid) begin
            result_d = op_res;
            z_f_d    = (op_res == '0);
            o_f_d    = op_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            z_f_q       <= 1'b0;
            o_f_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            z_f_q       <= z_f_d;
            o_f_q       <= o_f_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.z_f       = z_f_q;
    assign bus.o_f       = o_f_q;
endmodule

// File: tb/tb_alu64.sv
// Directed-vector bench for alu64: each operation is checked against a hand-computed result and flags.
module tb_alu64;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu64_if #(.WIDTH(64)) bus ();

    alu64 #(.WIDTH(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drives one operation at the falling edge and leaves in_valid high so calls can run back to back.
    task automatic applyStimulus(input logic [2:0] sel, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.sel      = sel;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk);
        #1;
    endtask

    task automatic runOp(input string tag, input logic [2:0] sel, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_res, input logic exp_z, input logic exp_o);
        applyStimulus(sel, a, b);
        checkOutput({tag, " valid"},  64'(bus.out_valid), 64'd1);
        checkOutput({tag, " result"}, bus.result, exp_res);
        checkOutput({tag, " z_f"},    64'(bus.z_f), 64'(exp_z));
        checkOutput({tag, " o_f"},    64'(bus.o_f), 64'(exp_o));
    endtask

    task automatic idleCheck(input string tag, input logic [63:0] exp_res, input logic exp_z, input logic exp_o);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.sel      = 3'b000;
        bus.a        = 64'h1234;
        bus.b        = 64'h5678;
        @(posedge clk);
        #1;
        checkOutput({tag, " valid"},  64'(bus.out_valid), 64'd0);
        checkOutput({tag, " result"}, bus.result, exp_res);
        checkOutput({tag, " z_f"},    64'(bus.z_f), 64'(exp_z));
        checkOutput({tag, " o_f"},    64'(bus.o_f), 64'(exp_o));
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.sel      = 3'b000;
        bus.a        = 64'd6;
        bus.b        = 64'd3;

        // Reset wins over a valid issue held for two cycles.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset valid",  64'(bus.out_valid), 64'd0);
        checkOutput("reset result", bus.result, 64'd0);
        checkOutput("reset z_f",    64'(bus.z_f), 64'd0);
        checkOutput("reset o_f",    64'(bus.o_f), 64'd0);

        @(negedge clk);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post-reset idle valid", 64'(bus.out_valid), 64'd0);

        runOp("add 6+3",      3'b000, 64'd6, 64'd3, 64'd9, 1'b0, 1'b0);
        idleCheck("hold after add", 64'd9, 1'b0, 1'b0);
        runOp("add 12+-12",   3'b000, 64'd12, 64'hFFFF_FFFF_FFFF_FFF4, 64'd0, 1'b1, 1'b0);
        runOp("add ovf",      3'b000, 64'h7000_0000_0000_0000, 64'h7000_0000_0000_0000,
              64'hE000_0000_0000_0000, 1'b0, 1'b1);

        runOp("sub 6-6",      3'b001, 64'd6, 64'd6, 64'd0, 1'b1, 1'b0);
        runOp("sub 12--12",   3'b001, 64'd12, 64'hFFFF_FFFF_FFFF_FFF4, 64'd24, 1'b0, 1'b0);
        runOp("sub big-big",  3'b001, 64'h7000_0000_0000_0000, 64'h7000_0000_0000_0000, 64'd0, 1'b1, 1'b0);
        runOp("sub ovf",      3'b001, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);

        runOp("mul 5*5",      3'b010, 64'd5, 64'd5, 64'd25, 1'b0, 1'b0);
        runOp("mul 4*0",      3'b010, 64'd4, 64'd0, 64'd0, 1'b1, 1'b0);
        runOp("mul -12*4",    3'b010, 64'hFFFF_FFFF_FFFF_FFF4, 64'd4, 64'hFFFF_FFFF_FFFF_FFD0, 1'b0, 1'b0);
        runOp("mul ovf",      3'b010, 64'h7000_0000_0000_0000, 64'd2, 64'hE000_0000_0000_0000, 1'b0, 1'b1);

        runOp("div 5/5",      3'b011, 64'd5, 64'd5, 64'd1, 1'b0, 1'b0);
        runOp("div 4/0",      3'b011, 64'd4, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        runOp("div -12/4",    3'b011, 64'hFFFF_FFFF_FFFF_FFF4, 64'd4, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0);
        runOp("div -7/2",     3'b011, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0);
        runOp("div big/2",    3'b011, 64'h7000_0000_0000_0000, 64'd2, 64'h3800_0000_0000_0000, 1'b0, 1'b0);
        runOp("div min/-1",   3'b011, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h8000_0000_0000_0000, 1'b0, 1'b1);

        runOp("rsvd 110",     3'b110, 64'd7, 64'd9, 64'd0, 1'b1, 1'b0);
        runOp("rsvd 111",     3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0);

        // Logic ops issued on consecutive cycles, one result per cycle.
        runOp("and ones&aa",  3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'hAAAA_AAAA_AAAA_AAAA,
              64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 1'b0);
        runOp("and ones&0",   3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 1'b1, 1'b0);
        runOp("or 55|aa",     3'b101, 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA,
              64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        runOp("or 0|0",       3'b101, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0);
        idleCheck("hold after or", 64'd0, 1'b1, 1'b0);

        // A reset arriving together with a valid issue discards it.
        runOp("pre-reset div0", 3'b011, 64'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        @(negedge clk);
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.sel      = 3'b000;
        bus.a        = 64'd1;
        bus.b        = 64'd1;
        @(posedge clk);
        #1;
        checkOutput("mid reset valid",  64'(bus.out_valid), 64'd0);
        checkOutput("mid reset result", bus.result, 64'd0);
        checkOutput("mid reset o_f",    64'(bus.o_f), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        runOp("after reset add", 3'b000, 64'd2, 64'd2, 64'd4, 1'b0, 1'b0);

        @(negedge clk);
        bus.in_valid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu64.md
Name: alu64

Overview:
Registered 64-bit signed integer ALU for the single-cycle processor datapath. Supports add, subtract, multiply, divide, AND and OR, selected by a 3-bit opcode. Produces a result plus zero and overflow flags, all registered one clock after the operands are sampled.

Parameters:
WIDTH, 64, operand/result width in bits; all arithmetic is two's-complement signed.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  synchronous, active-low reset.
in_valid  input  1  operands and opcode are valid this cycle.
a  input  WIDTH  operand A (signed).
b  input  WIDTH  operand B (signed).
sel  input  3  opcode: 000 add, 001 sub, 010 mul, 011 div, 100 AND, 101 OR, 110/111 reserved.
out_valid  output  1  result/flags hold a new operation's outcome.
result  output  WIDTH  operation result (low WIDTH bits).
z_f  output  1  zero flag: result == 0.
o_f  output  1  overflow / error flag.

Behaviour:
- Reset: on a rising clk edge with rst_n=0, drive result=0, z_f=0, o_f=0 and out_valid=0. Reset overrides in_valid in the same cycle.
- Latency: one cycle. With in_valid=1 at edge N, the outcome appears after edge N and out_valid=1.
- With in_valid=0 at an edge, out_valid=0 and result, z_f and o_f hold their previous values. No backpressure; back-to-back issue every cycle is allowed.
- add: result=a+b mod 2^WIDTH. o_f=1 iff the operand signs are equal and the result sign differs.
- sub: result=a-b mod 2^WIDTH. o_f=1 iff the operand signs differ and the result sign differs from a.
- mul: signed full product of 2*WIDTH bits. result=low WIDTH bits. o_f=1 iff the full product is not representable in signed WIDTH, i.e. the upper WIDTH bits are not all equal to result[WIDTH-1].
- div: signed quotient, truncated toward zero; the remainder is discarded.
  - b=0: result=all ones, o_f=1.
  - a=most-negative and b=-1: result=a (most-negative), o_f=1.
  - Otherwise o_f=0.
- AND / OR: bitwise; o_f=0.
- Reserved opcodes (110, 111): result=0, o_f=0, z_f=1.
- z_f is computed from the registered result value and is independent of o_f. For example, divide-by-zero gives z_f=0.
- Compute combinationally from the inputs and capture in the output registers. No internal state besides the output registers.
- Reset asserted mid-stream discards the in-flight operation; out_valid=0 on the following cycle.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 for 2 cycles -> result=0, z_f=0, o_f=0, out_valid=0. After release, out_valid rises one cycle after the first valid issue.
- Add:
  - 6+3 -> 9, z=0, o=0.
  - 12+(-12) -> 0, z=1, o=0.
  - 0x7000000000000000+0x7000000000000000 -> 0xE000000000000000, o=1.
- Sub:
  - 6-6 -> 0, z=1.
  - 12-(-12) -> 24, o=0.
  - 0x7000000000000000-0x7000000000000000 -> 0, z=1, o=0.
- Mul:
  - 5*5 -> 25.
  - 4*0 -> 0, z=1.
  - -12*4 -> 0xFFFFFFFFFFFFFFD0, o=0.
  - 0x7000000000000000*2 -> 0xE000000000000000, o=1.
- Div:
  - 5/5 -> 1.
  - 4/0 -> 0xFFFFFFFFFFFFFFFF, o=1, z=0.
  - -12/4 -> 0xFFFFFFFFFFFFFFFD.
  - 0x7000000000000000/2 -> 0x3800000000000000.
  - 0x8000000000000000/-1 -> 0x8000000000000000, o=1.
- Logic, back-to-back issue with one result per cycle:
  - AND 0xFFFFFFFFFFFFFFFF & 0xAAAAAAAAAAAAAAAA -> 0xAAAAAAAAAAAAAAAA.
  - AND 0xFFFFFFFFFFFFFFFF & 0 -> 0, z=1.
  - OR 0x5555555555555555 | 0xAAAAAAAAAAAAAAAA -> 0xFFFFFFFFFFFFFFFF.
  - OR 0|0 -> 0, z=1.
  - Drop in_valid -> outputs hold, out_valid=0.
